// File: rtl/alu_arb_pkg.sv
// Shared opcodes, FSM state encoding and request record for the two-requester ALU arbiter.
package alu_arb_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_NOT  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_CMP  = 3'b110;
  localparam logic [2:0] OP_ZERO = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } req_t;

endpackage

// File: rtl/alu_arbiter_alu4.sv
// Purely combinational 4-bit two's-complement ALU; ADD/SUB overflow forces a zero result.
module alu4
  import alu_arb_pkg::*;
(
  input  logic [2:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] result,
  output logic       overflow,
  output logic       zero
);

  logic [4:0] sum;

  always_comb begin
    sum      = '0;
    result   = '0;
    overflow = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        sum = (op == OP_SUB) ? ({a[3], a} - {b[3], b}) : ({a[3], a} + {b[3], b});
        if (sum[4] != sum[3]) overflow = 1'b1;
        else                  result   = sum[3:0];
      end
      OP_NOT:  result = ~a;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_CMP:  result = {3'b000, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == 4'h0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu4 between two requesters; capture -> execute -> respond.
// Define ALU_ARB_FIXED_PRIO_EN to give requester 0 fixed priority and drop the last_grant register.
//
// state   | meaning
// IDLE    | waiting for a valid request; winner's ready asserted, operands captured
// EXEC    | ALU evaluates captured operands; result registered into response regs
// RESP    | resp_valid high, outputs held until resp_ready
module alu_arbiter
  import alu_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [2:0] req0_op,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [2:0] req1_op,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       req1_ready,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_id,
  output logic [3:0] resp_result,
  output logic       resp_overflow,
  output logic       resp_zero
);

  state_t     state;
  req_t       opnd;
  logic       opnd_id;
  logic       grant0, grant1, in_idle;
  logic [3:0] alu_result;
  logic       alu_overflow, alu_zero;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant0 = req0_valid;
`else
  logic last_grant;

  // Requester 0 wins alone, or on a tie when requester 1 was served last.
  assign grant0 = req0_valid && (!req1_valid || last_grant);

  always_ff @(posedge clk) begin
    if (rst)                                   last_grant <= 1'b1;
    else if (state == ST_RESP && resp_ready)   last_grant <= resp_id;
  end
`endif

  assign grant1     = req1_valid && !grant0;
  assign in_idle    = (state == ST_IDLE) && !rst;
  assign req0_ready = in_idle && grant0;
  assign req1_ready = in_idle && grant1;
  assign resp_valid = (state == ST_RESP);

  alu4 u_alu4 (
    .op       (opnd.op),
    .a        (opnd.a),
    .b        (opnd.b),
    .result   (alu_result),
    .overflow (alu_overflow),
    .zero     (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      opnd          <= '0;
      opnd_id       <= 1'b0;
      resp_id       <= 1'b0;
      resp_result   <= 4'h0;
      resp_overflow <= 1'b0;
      resp_zero     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant0 || grant1) begin
            opnd    <= grant0 ? {req0_op, req0_a, req0_b} : {req1_op, req1_a, req1_b};
            opnd_id <= grant1;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resp_result   <= alu_result;
          resp_overflow <= alu_overflow;
          resp_zero     <= alu_zero;
          resp_id       <= opnd_id;
          state         <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, randomized ops against a reference model, corner sequences.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [2:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       resp_valid, resp_ready, resp_id;
  logic [3:0] resp_result;
  logic       resp_overflow, resp_zero;

  int total = 0;
  int bad   = 0;

  alu_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .req0_valid    (req0_valid),
    .req0_op       (req0_op),
    .req0_a        (req0_a),
    .req0_b        (req0_b),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_op       (req1_op),
    .req1_a        (req1_a),
    .req1_b        (req1_b),
    .req1_ready    (req1_ready),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_result   (resp_result),
    .resp_overflow (resp_overflow),
    .resp_zero     (resp_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rq;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic       ovf;
    logic       zr;
  } vec_t;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Reference: signed integer arithmetic with a range check for 4-bit overflow.
  function automatic logic [5:0] model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int sa, sb, r;
    logic [3:0] res;
    logic ov;
    sa  = (a > 4'd7) ? int'(a) - 16 : int'(a);
    sb  = (b > 4'd7) ? int'(b) - 16 : int'(b);
    ov  = 1'b0;
    res = 4'h0;
    case (op)
      3'd0, 3'd1: begin
        r = (op == 3'd0) ? sa + sb : sa - sb;
        if (r > 7 || r < -8) ov = 1'b1;
        else res = r[3:0];
      end
      3'd2: res = ~a;
      3'd3: res = a & b;
      3'd4: res = a | b;
      3'd5: res = a ^ b;
      3'd6: res = (sa < sb) ? 4'h1 : 4'h0;
      default: res = 4'h0;
    endcase
    return {ov, (res == 4'h0), res};
  endfunction

  task automatic drive(input logic rq, input logic v, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    if (rq) begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
  endtask

  // One operation with resp_ready high; checks accept and two-cycle response latency.
  task automatic issue(input logic rq, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       output logic [3:0] res, output logic ov, output logic zr, output logic id);
    int n;
    @(posedge clk); #1;
    drive(rq, 1'b1, op, a, b);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rq ? req1_ready : req0_ready) && n < 20);
    chk("accept", 8'(rq ? req1_ready : req0_ready), 8'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("lat_exec", 8'(resp_valid), 8'd0);
    @(negedge clk);
    chk("lat_resp", 8'(resp_valid), 8'd1);
    res = resp_result; ov = resp_overflow; zr = resp_zero; id = resp_id;
    @(posedge clk); #1;
  endtask

  vec_t       vt[13];
  logic [3:0] g_res;
  logic       g_ov, g_zr, g_id;
  logic [5:0] expv;
  logic [6:0] hold;
  int         ids[$];
  int         cyc[$];
  int         n;

  initial begin
    vt[0]  = '{1'b0, 3'd0, 4'h3, 4'h4, 4'h7, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 3'd0, 4'h7, 4'h1, 4'h0, 1'b1, 1'b1};
    vt[2]  = '{1'b0, 3'd1, 4'h8, 4'h1, 4'h0, 1'b1, 1'b1};
    vt[3]  = '{1'b1, 3'd6, 4'hD, 4'h2, 4'h1, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 3'd6, 4'h2, 4'hD, 4'h0, 1'b0, 1'b1};
    vt[5]  = '{1'b1, 3'd2, 4'h5, 4'h0, 4'hA, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 3'd7, 4'h9, 4'h3, 4'h0, 1'b0, 1'b1};
    vt[7]  = '{1'b1, 3'd3, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 3'd4, 4'h5, 4'hA, 4'hF, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 3'd5, 4'hF, 4'hF, 4'h0, 1'b0, 1'b1};
    vt[10] = '{1'b0, 3'd1, 4'h3, 4'h5, 4'hE, 1'b0, 1'b0};
    vt[11] = '{1'b1, 3'd0, 4'h8, 4'h8, 4'h0, 1'b1, 1'b1};
    vt[12] = '{1'b0, 3'd0, 4'hF, 4'h1, 4'h0, 1'b0, 1'b1};

    rst = 1'b1;
    resp_ready = 1'b1;
    drive(1'b0, 1'b1, 3'd0, 4'h1, 4'h1);
    drive(1'b1, 1'b1, 3'd0, 4'h2, 4'h2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", 8'(req0_ready), 8'd0);
    chk("rst_ready1", 8'(req1_ready), 8'd0);
    chk("rst_resp_valid", 8'(resp_valid), 8'd0);
    chk("rst_resp_id", 8'(resp_id), 8'd0);
    chk("rst_resp_result", 8'(resp_result), 8'd0);
    chk("rst_resp_flags", 8'({resp_overflow, resp_zero}), 8'd0);

    // Both requesters valid straight out of reset.
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      chk("one_ready", 8'(req0_ready && req1_ready), 8'd0);
      if (resp_valid) begin
        chk("resp_no_ready", 8'({req0_ready, req1_ready}), 8'd0);
        chk("rr_result", 8'(resp_result), resp_id ? 8'd4 : 8'd2);
        ids.push_back(int'(resp_id));
        cyc.push_back(c);
      end
    end
    chk("rr_count", 8'(ids.size()), 8'd4);
    for (int i = 0; i < ids.size() && i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk("rr_id", 8'(ids[i]), 8'd0);
`else
      chk("rr_id", 8'(ids[i]), 8'(i % 2));
`endif
      chk("rr_cycle", 8'(cyc[i]), 8'(2 + 3 * i));
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (6) @(posedge clk);

    foreach (vt[i]) begin
      issue(vt[i].rq, vt[i].op, vt[i].a, vt[i].b, g_res, g_ov, g_zr, g_id);
      chk("vec_result", 8'(g_res), 8'(vt[i].res));
      chk("vec_overflow", 8'(g_ov), 8'(vt[i].ovf));
      chk("vec_zero", 8'(g_zr), 8'(vt[i].zr));
      chk("vec_id", 8'(g_id), 8'(vt[i].rq));
    end

    for (int i = 0; i < 40; i++) begin
      logic       rq;
      logic [2:0] op;
      logic [3:0] a, b;
      rq = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      expv = model(op, a, b);
      issue(rq, op, a, b, g_res, g_ov, g_zr, g_id);
      chk("rnd_result", 8'(g_res), 8'(expv[3:0]));
      chk("rnd_zero", 8'(g_zr), 8'(expv[4]));
      chk("rnd_overflow", 8'(g_ov), 8'(expv[5]));
      chk("rnd_id", 8'(g_id), 8'(rq));
    end

    // Back-pressure in RESP while requester 1 waits.
    @(posedge clk); #1;
    resp_ready = 1'b0;
    drive(1'b0, 1'b1, 3'd0, 4'h2, 4'h3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req0_ready && n < 20);
    chk("bp_accept", 8'(req0_ready), 8'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    drive(1'b1, 1'b1, 3'd5, 4'h6, 4'h3);
    @(negedge clk);
    chk("bp_exec_ready1", 8'(req1_ready), 8'd0);
    @(negedge clk);
    chk("bp_resp_valid", 8'(resp_valid), 8'd1);
    chk("bp_result", 8'(resp_result), 8'd5);
    hold = {resp_id, resp_result, resp_overflow, resp_zero};
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_valid", 8'(resp_valid), 8'd1);
      chk("bp_hold_outputs", 8'({resp_id, resp_result, resp_overflow, resp_zero}), 8'(hold));
      chk("bp_hold_readys", 8'({req0_ready, req1_ready}), 8'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_next_grant", 8'(req1_ready), 8'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_next_resp", 8'({resp_valid, resp_id, resp_result}), 8'({1'b1, 1'b1, 4'h5}));
    @(posedge clk); #1;

    // Reset in EXEC: in-flight op discarded, pointer back to requester 0.
    issue(1'b0, 3'd0, 4'h1, 4'h1, g_res, g_ov, g_zr, g_id);
    chk("pre_rst_result", 8'(g_res), 8'd2);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 3'd0, 4'h1, 4'h2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req1_ready && n < 20);
    chk("rst_case_accept", 8'(req1_ready), 8'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_exec_outputs",
        8'({resp_valid, resp_id, resp_result, resp_overflow, resp_zero}), 8'd0);
    chk("rst_exec_readys", 8'({req0_ready, req1_ready}), 8'd0);
    drive(1'b0, 1'b1, 3'd0, 4'h5, 4'h1);
    drive(1'b1, 1'b1, 3'd0, 4'h1, 4'h1);
    #1;
    chk("post_rst_grant", 8'({req0_ready, req1_ready}), 8'b10);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_resp", 8'({resp_valid, resp_id, resp_result}), 8'({1'b1, 1'b0, 4'h6}));
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
